// File: rtl/shift_inc_pkg.sv
// Shared types and the shift-or-increment transform for the shift_inc scheduler.
// Operands are zero-extended to XFORM_W and callers truncate back to their own width.
package shift_inc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    localparam int XFORM_W = 32;

    function automatic logic [XFORM_W-1:0] xform(
        input logic [XFORM_W-1:0] operand,
        input int unsigned        shift_value
    );
        if (operand[0]) begin
            return operand << shift_value;
        end
        return operand + XFORM_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request after ptr, wrapping.
// Purely combinational; no backpressure of its own.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        logic [ID_W-1:0] cand;
        logic            found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Offset 1 first so the last winner ends up lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/shift_inc_sched.sv
// Shares one shift-or-increment unit round-robin between NUM_REQ requesters.
// Accept -> CALC -> RESP, rsp_valid after the second edge; rsp_valid holds until rsp_ready.
module shift_inc_sched
    import shift_inc_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int WIDTH       = 4,
    parameter  int SHIFT_VALUE = 1,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
    } job_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     ptr;
    job_t                job;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // Gated by rst_n so no grant is advertised while reset is being applied.
    assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
    assign accept    = |req_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= ID_W'(NUM_REQ - 1);
            job       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (accept) begin
                job.id   <= gnt_idx;
                job.data <= req_data[gnt_idx*WIDTH +: WIDTH];
                ptr      <= gnt_idx;
            end
            if (state == CALC) begin
                rsp_data  <= WIDTH'(xform(XFORM_W'(job.data), $unsigned(SHIFT_VALUE)));
                rsp_id    <= job.id;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
